decode_stage: RTL and testbench

Decode/register-read stage directly upstream of the ALU. Accepts 32-bit RV32 instructions over a valid/ready handshake and splits them into the ALU's `opcode`/`funct7`/`funct3`/`imm` fields. Reads operands from an internal 32x32 register file and presents everything to the ALU through one output pipeline register. ALU results return on the writeback port; a per-register pending scoreboard stalls instructions that would read stale data.

---
 rtl/decode_stage.sv | 126 ++++++++++++
 tb/tb_decode_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode/register-read stage ahead of the ALU: splits RV32 instructions into ALU fields,
// reads operands from a 32x32 register file and stalls on pending destination registers.
module decode_stage #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [6:0]  opcode,
    output logic [6:0]  funct7,
    output logic [2:0]  funct3,
    output logic [11:0] imm,
    output logic [31:0] rs1_val,
    output logic [31:0] rs2_val,
    output logic [4:0]  rd_addr,
    output logic        illegal
);

    logic [31:0] rf [32];
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        is_r, is_i, is_u, legal, shift_imm;
    logic [31:0] use_mask, clr_mask;
    logic        hazard, accept;
    logic [31:0] rs1_fwd, rs2_fwd;
    logic [6:0]  d_funct7;
    logic [11:0] d_imm;
    logic [31:0] d_rs1, d_rs2;

    assign op  = instr[6:0];
    assign rd  = instr[11:7];
    assign f3  = instr[14:12];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];

    assign is_r      = (op == 7'b0110011);
    assign is_i      = (op == 7'b0010011);
    assign is_u      = (op == 7'b0110111) || (op == 7'b0010111);
    assign legal     = is_r || is_i || is_u;
    assign shift_imm = is_i && ((f3 == 3'b001) || (f3 == 3'b101));

    // Only registers the instruction actually uses can stall it; x0 never does.
    always_comb begin
        use_mask = '0;
        if (is_r || is_i) use_mask[rs1] = 1'b1;
        if (is_r)         use_mask[rs2] = 1'b1;
        if (legal)        use_mask[rd]  = 1'b1;
        use_mask[0] = 1'b0;
    end

    always_comb begin
        clr_mask = '0;
        if (BYPASS && wb_en) clr_mask[wb_addr] = 1'b1;
    end

    assign hazard      = |(use_mask & pending & ~clr_mask);
    assign instr_ready = !rst && (!ex_valid || ex_ready) && !hazard;
    assign accept      = instr_valid && instr_ready;

    assign rs1_fwd = (rs1 == 5'd0) ? '0 :
                     (BYPASS && wb_en && (wb_addr == rs1)) ? wb_data : rf[rs1];
    assign rs2_fwd = (rs2 == 5'd0) ? '0 :
                     (BYPASS && wb_en && (wb_addr == rs2)) ? wb_data : rf[rs2];

    // Illegal opcodes keep R-type field slicing but carry no operands.
    assign d_funct7 = (is_r || shift_imm || !legal) ? instr[31:25] : '0;
    assign d_imm    = shift_imm       ? {7'b0, instr[24:20]} :
                      (is_i || is_u)  ? instr[31:20] : '0;
    assign d_rs1    = (is_r || is_i) ? rs1_fwd : '0;
    assign d_rs2    = is_r ? rs2_fwd : '0;

    // Set after clear so an issue to the register being written back stays pending.
    always_comb begin
        pending_nxt = pending;
        if (wb_en) pending_nxt[wb_addr] = 1'b0;
        if (accept && legal && (rd != 5'd0)) pending_nxt[rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
            pending <= '0;
        end else begin
            if (wb_en && (wb_addr != 5'd0)) rf[wb_addr] <= wb_data;
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            opcode   <= '0;
            funct7   <= '0;
            funct3   <= '0;
            imm      <= '0;
            rs1_val  <= '0;
            rs2_val  <= '0;
            rd_addr  <= '0;
            illegal  <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            opcode   <= op;
            funct7   <= d_funct7;
            funct3   <= f3;
            imm      <= d_imm;
            rs1_val  <= d_rs1;
            rs2_val  <= d_rs2;
            rd_addr  <= rd;
            illegal  <= !legal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: constant vector table, directed backpressure/reset sequences,
// and randomized traffic checked against a spec-level model of the stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        illegal;

    always #5 clk = ~clk;

    decode_stage #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .opcode(opcode), .funct7(funct7), .funct3(funct3), .imm(imm),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr), .illegal(illegal)
    );

    typedef struct packed {
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rd;
        logic        ill;
    } fields_t;

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        er;
        logic        x_rdy;
        logic        x_exv;
        fields_t     x;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Spec-level model state
    logic [31:0] m_rf [32];
    logic [31:0] m_pend;
    logic        m_exv;
    fields_t     m_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_out(input string tag, input fields_t e);
        check({tag, ".opcode"},  opcode,  e.op);
        check({tag, ".funct7"},  funct7,  e.f7);
        check({tag, ".funct3"},  funct3,  e.f3);
        check({tag, ".imm"},     imm,     e.imm);
        check({tag, ".rs1_val"}, rs1_val, e.r1);
        check({tag, ".rs2_val"}, rs2_val, e.r2);
        check({tag, ".rd_addr"}, rd_addr, e.rd);
        check({tag, ".illegal"}, illegal, e.ill);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_pend = '0;
        m_exv  = 1'b0;
        m_out  = '0;
    endtask

    function automatic logic [31:0] read_op(input logic [4:0] s, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (s == 0) return 32'd0;
        if (we && wa == s) return wd;
        return m_rf[s];
    endfunction

    function automatic fields_t model_decode(input logic [31:0] ins, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        fields_t f;
        logic [2:0] f3;
        f3 = ins[14:12];
        f = '0;
        f.op = ins[6:0];
        f.f3 = f3;
        f.rd = ins[11:7];
        case (ins[6:0])
            7'b0110011: begin
                f.f7 = ins[31:25];
                f.r1 = read_op(ins[19:15], we, wa, wd);
                f.r2 = read_op(ins[24:20], we, wa, wd);
            end
            7'b0010011: begin
                f.r1 = read_op(ins[19:15], we, wa, wd);
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    f.f7  = ins[31:25];
                    f.imm = {7'b0, ins[24:20]};
                end else begin
                    f.imm = ins[31:20];
                end
            end
            7'b0110111, 7'b0010111: f.imm = ins[31:20];
            default: begin
                f.f7  = ins[31:25];
                f.ill = 1'b1;
            end
        endcase
        return f;
    endfunction

    function automatic bit model_hazard(input logic [31:0] ins, input logic we, input logic [4:0] wa);
        logic [4:0] srcs[$];
        case (ins[6:0])
            7'b0110011: begin srcs.push_back(ins[19:15]); srcs.push_back(ins[24:20]); srcs.push_back(ins[11:7]); end
            7'b0010011: begin srcs.push_back(ins[19:15]); srcs.push_back(ins[11:7]); end
            7'b0110111, 7'b0010111: srcs.push_back(ins[11:7]);
            default: ;
        endcase
        foreach (srcs[i])
            if (srcs[i] != 0 && m_pend[srcs[i]] && !(we && wa == srcs[i])) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle: drive after the falling edge, check readiness, clock, check outputs.
    task automatic step(input logic v, input logic [31:0] ins, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic er, output logic rdy_seen);
        logic    exp_rdy;
        fields_t nf;
        instr_valid = v; instr = ins; wb_en = we; wb_addr = wa; wb_data = wd; ex_ready = er;
        #2;
        exp_rdy = (!m_exv || er) && !model_hazard(ins, we, wa);
        rdy_seen = instr_ready;
        check("instr_ready", instr_ready, exp_rdy);
        nf = model_decode(ins, we, wa, wd);
        @(posedge clk);
        if (v && exp_rdy) begin m_out = nf; m_exv = 1'b1; end
        else if (er) m_exv = 1'b0;
        if (we) m_pend[wa] = 1'b0;
        if (v && exp_rdy && !nf.ill && nf.rd != 0) m_pend[nf.rd] = 1'b1;
        if (we && wa != 0) m_rf[wa] = wd;
        #1;
        check("ex_valid", ex_valid, m_exv);
        if (m_exv) cmp_out("model", m_out);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic er, input logic rdy, input logic exv,
                                input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                input logic [11:0] im, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [4:0] rd, input logic ill);
        vec_t t;
        t.v = v; t.ins = ins; t.we = we; t.wa = wa; t.wd = wd; t.er = er;
        t.x_rdy = rdy; t.x_exv = exv;
        t.x.op = op; t.x.f7 = f7; t.x.f3 = f3; t.x.imm = im;
        t.x.r1 = r1; t.x.r2 = r2; t.x.rd = rd; t.x.ill = ill;
        return t;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  a, b, d;
        logic [2:0]  f3;
        r  = $urandom;
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       return {r[31:25], b, a, f3, d, 7'b0110011};
            1:       return {r[31:20], a, f3, d, 7'b0010011};
            2:       return {r[31:12], d, 7'b0110111};
            default: return {r[31:12], d, 7'b0010111};
        endcase
    endfunction

    vec_t vt[13];
    logic rs;

    initial begin
        vt[0]  = mk(1, 32'h00500093, 0, 0, 32'h0,        1, 1, 1, 7'h13, 7'h00, 3'd0, 12'h005, 32'h0,        32'h0, 5'd1, 0);
        vt[1]  = mk(1, 32'h00108133, 0, 0, 32'h0,        1, 0, 0, 7'h00, 7'h00, 3'd0, 12'h000, 32'h0,        32'h0, 5'd0, 0);
        vt[2]  = mk(1, 32'h00108133, 0, 0, 32'h0,        1, 0, 0, 7'h00, 7'h00, 3'd0, 12'h000, 32'h0,        32'h0, 5'd0, 0);
        vt[3]  = mk(1, 32'h00108133, 1, 1, 32'h5,        1, 1, 1, 7'h33, 7'h00, 3'd0, 12'h000, 32'h5,        32'h5, 5'd2, 0);
        vt[4]  = mk(1, 32'h4040D193, 1, 1, 32'h80000000, 1, 1, 1, 7'h13, 7'h20, 3'd5, 12'h004, 32'h80000000, 32'h0, 5'd3, 0);
        vt[5]  = mk(0, 32'h00000000, 1, 2, 32'h7,        1, 1, 0, 7'h00, 7'h00, 3'd0, 12'h000, 32'h0,        32'h0, 5'd0, 0);
        vt[6]  = mk(0, 32'h00000000, 1, 3, 32'h9,        1, 1, 0, 7'h00, 7'h00, 3'd0, 12'h000, 32'h0,        32'h0, 5'd0, 0);
        vt[7]  = mk(1, 32'h00000233, 1, 0, 32'hFFFFFFFF, 1, 1, 1, 7'h33, 7'h00, 3'd0, 12'h000, 32'h0,        32'h0, 5'd4, 0);
        vt[8]  = mk(1, 32'h00100013, 0, 0, 32'h0,        1, 1, 1, 7'h13, 7'h00, 3'd0, 12'h001, 32'h0,        32'h0, 5'd0, 0);
        vt[9]  = mk(1, 32'h00000333, 0, 0, 32'h0,        1, 1, 1, 7'h33, 7'h00, 3'd0, 12'h000, 32'h0,        32'h0, 5'd6, 0);
        vt[10] = mk(1, 32'h00000183, 1, 4, 32'h1,        1, 1, 1, 7'h03, 7'h00, 3'd0, 12'h000, 32'h0,        32'h0, 5'd3, 1);
        vt[11] = mk(1, 32'h003182B3, 1, 6, 32'h2,        1, 1, 1, 7'h33, 7'h00, 3'd0, 12'h000, 32'h9,        32'h9, 5'd5, 0);
        vt[12] = mk(0, 32'h00000000, 1, 5, 32'h0,        1, 1, 0, 7'h00, 7'h00, 3'd0, 12'h000, 32'h0,        32'h0, 5'd0, 0);

        rst = 1'b1;
        instr_valid = 1'b0; instr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.ex_valid", ex_valid, 0);
        check("rst.instr_ready", instr_ready, 0);
        cmp_out("rst", '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(vt[i].v, vt[i].ins, vt[i].we, vt[i].wa, vt[i].wd, vt[i].er, rs);
            check($sformatf("tbl%0d.instr_ready", i), rs, vt[i].x_rdy);
            check($sformatf("tbl%0d.ex_valid", i), ex_valid, vt[i].x_exv);
            if (vt[i].x_exv) cmp_out($sformatf("tbl%0d", i), vt[i].x);
        end

        // Backpressure: ADDI x7,x0,3 sits in the output register for 3 stalled cycles.
        step(1, 32'h00300393, 0, 0, 0, 1, rs);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00208433, 0, 0, 0, 0, rs);
            check("bp.instr_ready", rs, 0);
            check("bp.hold_rd", rd_addr, 5'd7);
            check("bp.hold_imm", imm, 12'h003);
            check("bp.hold_valid", ex_valid, 1);
        end
        step(1, 32'h00208433, 0, 0, 0, 1, rs);
        check("bp.release_ready", rs, 1);
        check("bp.next_rd", rd_addr, 5'd8);
        check("bp.next_rs1", rs1_val, 32'h80000000);
        check("bp.next_rs2", rs2_val, 32'h7);
        step(0, 0, 1, 7, 32'h11, 1, rs);
        step(0, 0, 1, 8, 32'h22, 1, rs);

        // Asynchronous reset while an instruction is held downstream.
        step(1, 32'h00500093, 0, 0, 0, 0, rs);
        check("mid.ex_valid_before", ex_valid, 1);
        instr_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid.ex_valid", ex_valid, 0);
        check("mid.instr_ready", instr_ready, 0);
        cmp_out("mid", '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1, 32'h00108133, 0, 0, 0, 1, rs);
        check("mid.first_accept", rs, 1);
        check("mid.rs1_zero", rs1_val, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] ins, wd;
            logic        v, we, er;
            logic [4:0]  wa;
            int          pend_list[$];
            for (int r = 1; r < 32; r++) if (m_pend[r]) pend_list.push_back(r);
            ins = rand_instr();
            v   = ($urandom_range(0, 3) != 0);
            er  = ($urandom_range(0, 3) != 0);
            wd  = $urandom;
            we  = 1'b0;
            wa  = '0;
            if (pend_list.size() > 0 && $urandom_range(0, 1) == 1) begin
                we = 1'b1;
                wa = 5'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
            end else if ($urandom_range(0, 7) == 0) begin
                we = 1'b1;
                wa = 5'($urandom_range(0, 31));
            end
            step(v, ins, we, wa, wd, er, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
